board_update_ctrl: RTL and testbench



---
 rtl/board_update_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_board_update_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/board_update_ctrl.sv
// board_update_ctrl
// Owns the 64x4 chessboard memory that the drawing pipeline reads every pixel.
// It arbitrates move requests from two requesters using round-robin. Moves are
// committed only inside vertical blanking. Frame-width changes are held until
// the next frame boundary.
module board_update_ctrl #(
  parameter int MAX_MOVES     = 2,
  parameter int FRAME_DEFAULT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic [1:0]  req_valid,
  input  logic [11:0] req_src,
  input  logic [11:0] req_dst,
  output logic [1:0]  req_ready,
  output logic        done,
  output logic        done_err,
  output logic        done_id,
  input  logic [5:0]  rd_addr,
  output logic [3:0]  rd_data,
  input  logic        cfg_valid,
  input  logic [7:0]  cfg_frame_pixels,
  output logic [7:0]  frame_pixels,
  output logic        busy
);

  localparam int CNT_W = $clog2(MAX_MOVES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_MOVES);

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_RD_SRC, ST_WR_DST, ST_CLR_SRC, ST_FIN
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       init_cnt_q, init_cnt_d;
  logic [5:0]       src_q, src_d;
  logic [5:0]       dst_q, dst_d;
  logic             id_q, id_d;
  logic             err_q, err_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] mv_cnt_q, mv_cnt_d;
  logic             vblnk_q;
  logic [7:0]       cfg_pend_q, cfg_pend_d;
  logic             cfg_pend_vld_q, cfg_pend_vld_d;
  logic [7:0]       frame_q, frame_d;
  logic [1:0]       req_ready_q, req_ready_d;
  logic             done_q, done_d;
  logic             done_err_q, done_err_d;
  logic             done_id_q, done_id_d;
  logic             busy_q, busy_d;

  // Board storage with a drawing read port and a move-fetch read port
  logic [3:0] board_mem [64];
  logic [3:0] rd_data_q;
  logic [3:0] piece_q;
  logic       mem_we;
  logic [5:0] mem_waddr;
  logic [3:0] mem_wdata;
  logic [5:0] piece_raddr;

  // Per-requester views of the packed square buses
  logic [5:0] src_arr [2];
  logic [5:0] dst_arr [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign src_arr[gi] = req_src[gi*6 +: 6];
      assign dst_arr[gi] = req_dst[gi*6 +: 6];
    end
  endgenerate

  // Starting position: white back rank, white pawns, empty middle, black pawns,
  // black back rank (black codes are the white codes plus 8).
  function automatic logic [3:0] start_piece(input logic [5:0] sq);
    logic [3:0] back;
    case (sq[2:0])
      3'd0, 3'd7: back = 4'd4;
      3'd1, 3'd6: back = 4'd2;
      3'd2, 3'd5: back = 4'd3;
      3'd3:       back = 4'd5;
      default:    back = 4'd6;
    endcase
    case (sq[5:3])
      3'd0:    start_piece = back;
      3'd1:    start_piece = 4'd1;
      3'd6:    start_piece = 4'd9;
      3'd7:    start_piece = back + 4'd8;
      default: start_piece = 4'd0;
    endcase
  endfunction

  logic             vblnk_rise;
  logic [CNT_W-1:0] mv_cnt_eff;
  logic             gnt_ok;
  logic             gnt_id;

  // Next-state logic: window tracking, arbitration, move sequencing, config scheduling
  always_comb begin
    state_d        = state_q;
    init_cnt_d     = init_cnt_q;
    src_d          = src_q;
    dst_d          = dst_q;
    id_d           = id_q;
    err_d          = err_q;
    rr_d           = rr_q;
    cfg_pend_d     = cfg_pend_q;
    cfg_pend_vld_d = cfg_pend_vld_q;
    frame_d        = frame_q;
    req_ready_d    = 2'b00;
    done_d         = 1'b0;
    done_err_d     = 1'b0;
    done_id_d      = 1'b0;
    mem_we         = 1'b0;
    mem_waddr      = 6'd0;
    mem_wdata      = 4'd0;

    // A new blanking interval reopens the move budget in the same cycle
    vblnk_rise = vblnk & ~vblnk_q;
    mv_cnt_eff = vblnk_rise ? '0 : mv_cnt_q;
    mv_cnt_d   = mv_cnt_eff;

    gnt_ok = (state_q == ST_IDLE) && vblnk && (mv_cnt_eff < MAX_CNT) && (req_valid != 2'b00);
    gnt_id = (req_valid == 2'b11) ? rr_q : req_valid[1];

    // Fetch the source square at the grant edge so RD_SRC sees it immediately
    piece_raddr = (state_q == ST_IDLE) ? src_arr[gnt_id] : src_q;

    case (state_q)
      ST_INIT: begin
        mem_we     = 1'b1;
        mem_waddr  = init_cnt_q;
        mem_wdata  = start_piece(init_cnt_q);
        init_cnt_d = init_cnt_q + 6'd1;
        if (init_cnt_q == 6'd63) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (gnt_ok) begin
          req_ready_d[gnt_id] = 1'b1;
          src_d    = src_arr[gnt_id];
          dst_d    = dst_arr[gnt_id];
          id_d     = gnt_id;
          rr_d     = ~gnt_id;
          mv_cnt_d = mv_cnt_eff + CNT_W'(1);
          state_d  = ST_RD_SRC;
        end
      end
      ST_RD_SRC: begin
        if ((src_q == dst_q) || (piece_q == 4'd0)) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          err_d   = 1'b0;
          state_d = ST_WR_DST;
        end
      end
      ST_WR_DST: begin
        mem_we    = 1'b1;
        mem_waddr = dst_q;
        mem_wdata = piece_q;
        state_d   = ST_CLR_SRC;
      end
      ST_CLR_SRC: begin
        mem_we    = 1'b1;
        mem_waddr = src_q;
        mem_wdata = 4'd0;
        state_d   = ST_FIN;
      end
      ST_FIN: begin
        done_d     = 1'b1;
        done_err_d = err_q;
        done_id_d  = id_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase

    // A reset cycle must never disturb the board, even mid-move
    if (rst) mem_we = 1'b0;

    // Frame width only changes on a frame boundary; same-cycle request wins
    if (vblnk_rise) begin
      if (cfg_valid)           frame_d = cfg_frame_pixels;
      else if (cfg_pend_vld_q) frame_d = cfg_pend_q;
      cfg_pend_d     = 8'd0;
      cfg_pend_vld_d = 1'b0;
    end else if (cfg_valid) begin
      cfg_pend_d     = cfg_frame_pixels;
      cfg_pend_vld_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Controller state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_INIT;
      init_cnt_q     <= 6'd0;
      src_q          <= 6'd0;
      dst_q          <= 6'd0;
      id_q           <= 1'b0;
      err_q          <= 1'b0;
      rr_q           <= 1'b0;
      mv_cnt_q       <= '0;
      vblnk_q        <= 1'b0;
      cfg_pend_q     <= 8'd0;
      cfg_pend_vld_q <= 1'b0;
      frame_q        <= 8'(FRAME_DEFAULT);
      req_ready_q    <= 2'b00;
      done_q         <= 1'b0;
      done_err_q     <= 1'b0;
      done_id_q      <= 1'b0;
      busy_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      init_cnt_q     <= init_cnt_d;
      src_q          <= src_d;
      dst_q          <= dst_d;
      id_q           <= id_d;
      err_q          <= err_d;
      rr_q           <= rr_d;
      mv_cnt_q       <= mv_cnt_d;
      vblnk_q        <= vblnk;
      cfg_pend_q     <= cfg_pend_d;
      cfg_pend_vld_q <= cfg_pend_vld_d;
      frame_q        <= frame_d;
      req_ready_q    <= req_ready_d;
      done_q         <= done_d;
      done_err_q     <= done_err_d;
      done_id_q      <= done_id_d;
      busy_q         <= busy_d;
    end
  end

  // Board write port and move-fetch read (read-before-write on a shared address)
  always_ff @(posedge clk) begin
    if (mem_we) board_mem[mem_waddr] <= mem_wdata;
    piece_q <= board_mem[piece_raddr];
  end

  // Drawing read port, one-cycle latency, cleared while in reset
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= 4'd0;
    else     rd_data_q <= board_mem[rd_addr];
  end

  assign req_ready    = req_ready_q;
  assign done         = done_q;
  assign done_err     = done_err_q;
  assign done_id      = done_id_q;
  assign rd_data      = rd_data_q;
  assign frame_pixels = frame_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_board_update_ctrl.sv
// tb_board_update_ctrl
// Random two-requester traffic with varying blanking windows, config writes and a
// reset dropped into the middle of a move. The model here works in transactions: it
// tracks the board contents, when the controller is next free, and when each result is due.
module tb_board_update_ctrl;

  localparam int MAX_MOVES     = 2;
  localparam int FRAME_DEFAULT = 8;
  localparam int N_CYC         = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        vblnk;
  logic [1:0]  req_valid;
  logic [11:0] req_src;
  logic [11:0] req_dst;
  logic [1:0]  req_ready;
  logic        done;
  logic        done_err;
  logic        done_id;
  logic [5:0]  rd_addr;
  logic [3:0]  rd_data;
  logic        cfg_valid;
  logic [7:0]  cfg_frame_pixels;
  logic [7:0]  frame_pixels;
  logic        busy;

  board_update_ctrl #(.MAX_MOVES(MAX_MOVES), .FRAME_DEFAULT(FRAME_DEFAULT)) dut (
    .clk(clk), .rst(rst), .vblnk(vblnk),
    .req_valid(req_valid), .req_src(req_src), .req_dst(req_dst), .req_ready(req_ready),
    .done(done), .done_err(done_err), .done_id(done_id),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .cfg_valid(cfg_valid), .cfg_frame_pixels(cfg_frame_pixels), .frame_pixels(frame_pixels),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cur_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cur_cyc, got, exp);
    end
  endtask

  // Reference board and scheduling state
  int board [64];
  int back_rank [8] = '{4, 2, 3, 5, 6, 3, 2, 4};
  int dir_addr [6]  = '{0, 4, 8, 20, 52, 60};
  int dir_val  [6]  = '{4, 6, 1, 0, 9, 14};

  task automatic load_start();
    for (int sq = 0; sq < 64; sq++) begin
      case (sq / 8)
        0:       board[sq] = back_rank[sq % 8];
        1:       board[sq] = 1;
        6:       board[sq] = 9;
        7:       board[sq] = back_rank[sq % 8] + 8;
        default: board[sq] = 0;
      endcase
    end
  endtask

  initial begin
    logic [1:0] rq_v;
    logic [5:0] rq_s [2];
    logic [5:0] rq_d [2];
    int  idle_from, done_cyc, mv_g, win, rr, frame, pend, rst_cnt, dir_idx, next_dir;
    int  fpos, flen, vlen, req_pct, gid, s, d, pick;
    bit  vprev, pend_v, done_err_m, done_id_m, mv_err, rise, err, have_exp, did_mid_reset, rst_now;
    logic [1:0] e_ready;
    bit  e_done, e_derr, e_did, e_busy, e_rd_chk;
    int  e_frame, e_rd;

    rst = 1'b1; vblnk = 1'b0; req_valid = 2'b00; req_src = '0; req_dst = '0;
    rd_addr = '0; cfg_valid = 1'b0; cfg_frame_pixels = '0;
    rq_v = 2'b00; rq_s[0] = '0; rq_s[1] = '0; rq_d[0] = '0; rq_d[1] = '0;
    load_start();
    idle_from = 1 << 30; done_cyc = -1; mv_g = -10; mv_err = 1'b1; win = 0; rr = 0;
    frame = FRAME_DEFAULT; pend = 0; pend_v = 1'b0; vprev = 1'b0; rst_cnt = 0;
    dir_idx = -1; fpos = 0; flen = 40; vlen = 14; have_exp = 1'b0; did_mid_reset = 1'b0;
    done_err_m = 1'b0; done_id_m = 1'b0;
    e_ready = 2'b00; e_done = 0; e_derr = 0; e_did = 0; e_busy = 1; e_rd_chk = 0;
    e_frame = FRAME_DEFAULT; e_rd = 0;

    for (int k = 0; k < N_CYC; k++) begin
      cur_cyc = k;
      // Outputs now belong to cycle k
      if (have_exp) begin
        check("req_ready", 32'(req_ready), 32'(e_ready));
        check("done", 32'(done), 32'(e_done));
        check("done_err", 32'(done_err), 32'(e_derr));
        check("done_id", 32'(done_id), 32'(e_did));
        check("busy", 32'(busy), 32'(e_busy));
        check("frame_pixels", 32'(frame_pixels), 32'(e_frame));
        if (e_rd_chk) check("rd_data", 32'(rd_data), 32'(e_rd));
        if (dir_idx >= 0) check("rd_start", 32'(rd_data), 32'(dir_val[dir_idx]));
      end

      // Requesters drop their request once granted
      for (int i = 0; i < 2; i++) if (e_ready[i]) rq_v[i] = 1'b0;

      // New requests, mostly from occupied squares, sometimes a null move
      req_pct = (k < 1500) ? 20 : 100;
      for (int i = 0; i < 2; i++) begin
        if (k >= 100 && !rq_v[i] && $urandom_range(0, 99) < req_pct) begin
          rq_v[i] = 1'b1;
          rq_s[i] = 6'($urandom_range(0, 63));
          if ($urandom_range(0, 9) < 7) begin
            for (int t = 0; t < 8; t++) begin
              pick = $urandom_range(0, 63);
              if (board[pick] != 0) begin
                rq_s[i] = 6'(pick);
                break;
              end
            end
          end
          rq_d[i] = ($urandom_range(0, 9) == 0) ? rq_s[i] : 6'($urandom_range(0, 63));
        end
      end

      // Blanking pattern with randomised frame and blanking lengths
      vblnk = (fpos >= flen - vlen);
      fpos++;
      if (fpos == flen) begin
        fpos = 0;
        flen = $urandom_range(30, 50);
        vlen = $urandom_range(10, 18);
      end

      cfg_valid = ($urandom_range(0, 24) == 0);
      cfg_frame_pixels = 8'($urandom_range(0, 255));

      next_dir = -1;
      rd_addr = 6'(k);
      if (k >= 70 && k < 76) begin
        next_dir = k - 70;
        rd_addr = 6'(dir_addr[k - 70]);
      end

      // Reset: power-up, then once in the WR_DST cycle of a real move
      rst_now = (k < 4) || (rst_cnt > 0);
      if (rst_cnt > 0) rst_cnt--;
      if (!did_mid_reset && k > 2000 && k == mv_g + 1 && !mv_err && done_cyc > k) begin
        did_mid_reset = 1'b1;
        rst_now = 1'b1;
        rst_cnt = 1;
        $display("cyc %0d: reset asserted during move write", k + 1);
      end

      rst       = rst_now;
      req_valid = rq_v;
      req_src   = {rq_s[1], rq_s[0]};
      req_dst   = {rq_d[1], rq_d[0]};

      // Model: predict the outputs of cycle k+1
      e_ready = 2'b00;
      if (rst_now) begin
        load_start();
        idle_from = k + 1 + 64;
        done_cyc = -1; rr = 0; win = 0; pend_v = 1'b0; pend = 0;
        frame = FRAME_DEFAULT; vprev = 1'b0;
        e_rd_chk = 1'b1; e_rd = 0;
      end else begin
        rise = vblnk && !vprev;
        vprev = vblnk;
        if (rise) win = 0;
        e_rd_chk = (k >= idle_from);
        e_rd = board[rd_addr];
        if (k >= idle_from && vblnk && win < MAX_MOVES && rq_v != 2'b00) begin
          gid = (rq_v == 2'b11) ? rr : (rq_v[1] ? 1 : 0);
          e_ready[gid] = 1'b1;
          win++;
          rr = 1 - gid;
          s = rq_s[gid];
          d = rq_d[gid];
          err = (s == d) || (board[s] == 0);
          if (!err) begin
            board[d] = board[s];
            board[s] = 0;
          end
          mv_g = k + 1;
          mv_err = err;
          done_cyc = mv_g + (err ? 2 : 4);
          done_err_m = err;
          done_id_m = (gid == 1);
          idle_from = done_cyc;
          $display("cyc %0d: grant req%0d src=%0d dst=%0d %s", k + 1, gid, s, d,
                   err ? "reject" : "commit");
        end
        if (rise) begin
          if (cfg_valid)   frame = cfg_frame_pixels;
          else if (pend_v) frame = pend;
          pend_v = 1'b0;
        end else if (cfg_valid) begin
          pend = cfg_frame_pixels;
          pend_v = 1'b1;
        end
      end
      e_busy  = (k + 1 < idle_from);
      e_done  = (done_cyc == k + 1);
      e_derr  = e_done && done_err_m;
      e_did   = e_done && done_id_m;
      e_frame = frame;
      dir_idx = next_dir;
      have_exp = 1'b1;

      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
